clk_gen_ctrl: RTL and testbench

CLK_GEN_CTRL -- requirements
Module: clk_gen_ctrl

---
 rtl/clk_gen_ctrl.sv | 164 ++++++++++++++++
 tb/tb_clk_gen_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_gen_ctrl (with package clks_alot_p)
// Purpose  : Control FSM for a programmable clock generator. It accepts a
//            configuration over a valid/ready handshake and rejects zero-length
//            phases. It then initialises the generator and lets it run. Each
//            completed period is counted from the fed-back generator clock.
//            Generation stops after a programmed number of periods or on
//            request, always at a period boundary.
// Ports    : clk_i, arst_n_i                  clock, async active-low reset
//            clk_en_i                         domain clock enable
//            cfg_valid_i / cfg_ready_o        configuration handshake
//            cfg_high_rate_i, cfg_low_rate_i  phase lengths (enabled cycles)
//            cfg_polarity_i                   start/idle level
//            cfg_periods_i                    period target, 0 = continuous
//            stop_req_i                       stop at next period boundary
//            gen_clk_i                        generator clock fed back
//            gen_init_o, gen_en_o             generator init / enable
//            gen_high_rate_o, gen_low_rate_o, gen_polarity_o  latched config
//            busy_o, done_o, err_o            status (done/err are pulses)
//            period_count_o                   completed periods
// Revision : 1.0  initial release
// ============================================================================
package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 8;
endpackage

module clk_gen_ctrl #(
  parameter int RATE_W = clks_alot_p::RATE_COUNTER_WIDTH,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              clk_en_i,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [RATE_W-1:0] cfg_high_rate_i,
  input  logic [RATE_W-1:0] cfg_low_rate_i,
  input  logic              cfg_polarity_i,
  input  logic [CNT_W-1:0]  cfg_periods_i,
  input  logic              stop_req_i,
  input  logic              gen_clk_i,
  output logic              gen_init_o,
  output logic              gen_en_o,
  output logic [RATE_W-1:0] gen_high_rate_o,
  output logic [RATE_W-1:0] gen_low_rate_o,
  output logic              gen_polarity_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [CNT_W-1:0]  period_count_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e              state_q;
  logic [RATE_W-1:0]   high_q;
  logic [RATE_W-1:0]   low_q;
  logic                pol_q;
  logic [CNT_W-1:0]    target_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                stop_pending_q;
  logic                prev_q;
  logic                done_q;
  logic                err_q;

  logic                cfg_bad;
  logic                period_done;
  logic                terminate;

  assign cfg_bad = (cfg_high_rate_i == '0) || (cfg_low_rate_i == '0);

  // A period ends when the generator returns to its idle level.
  assign period_done = (state_q == RUN) && clk_en_i &&
                       (gen_clk_i == pol_q) && (prev_q != pol_q);

  assign count_d = count_q + CNT_W'(1);

  assign terminate = period_done &&
                     (((target_q != '0) && (count_d == target_q)) ||
                      stop_pending_q || stop_req_i);

  // Combinational so the generator freezes on the very cycle the final
  // edge is observed, which leaves it parked at its idle level.
  assign gen_en_o    = (state_q == RUN) && !terminate;
  assign gen_init_o  = (state_q == INIT);
  assign busy_o      = (state_q != IDLE);
  assign cfg_ready_o = (state_q == IDLE);

  assign gen_high_rate_o = high_q;
  assign gen_low_rate_o  = low_q;
  assign gen_polarity_o  = pol_q;
  assign done_o          = done_q;
  assign err_o           = err_q;
  assign period_count_o  = count_q;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q        <= IDLE;
      high_q         <= '0;
      low_q          <= '0;
      pol_q          <= 1'b0;
      target_q       <= '0;
      count_q        <= '0;
      stop_pending_q <= 1'b0;
      prev_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      // Pulses last one clock and never appear on a disabled cycle.
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (clk_en_i) begin
        case (state_q)
          IDLE: begin
            if (cfg_valid_i) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                high_q         <= cfg_high_rate_i;
                low_q          <= cfg_low_rate_i;
                pol_q          <= cfg_polarity_i;
                target_q       <= cfg_periods_i;
                count_q        <= '0;
                stop_pending_q <= 1'b0;
                state_q        <= INIT;
              end
            end
          end
          INIT: begin
            // Seed the edge detector so the first RUN cycle at the idle
            // level is not mistaken for a completed period.
            prev_q <= pol_q;
            if (stop_req_i) begin
              stop_pending_q <= 1'b1;
            end
            state_q <= RUN;
          end
          RUN: begin
            prev_q <= gen_clk_i;
            if (period_done) begin
              count_q <= count_d;
            end
            if (terminate) begin
              stop_pending_q <= 1'b0;
              done_q         <= 1'b1;
              state_q        <= IDLE;
            end else if (stop_req_i) begin
              stop_pending_q <= 1'b1;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_gen_ctrl
// Purpose  : Directed self-checking bench for clk_gen_ctrl. It includes a
//            behavioural clock generator that closes the gen_clk_i loop.
// Revision : 1.0  initial release
// ============================================================================
module tb_clk_gen_ctrl;

  localparam int RATE_W = 8;
  localparam int CNT_W  = 4;

  logic              clk;
  logic              arst_n;
  logic              clk_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [RATE_W-1:0] cfg_high;
  logic [RATE_W-1:0] cfg_low;
  logic              cfg_pol;
  logic [CNT_W-1:0]  cfg_periods;
  logic              stop_req;
  logic              gclk;
  logic              gen_init;
  logic              gen_en;
  logic [RATE_W-1:0] gen_high;
  logic [RATE_W-1:0] gen_low;
  logic              gen_pol;
  logic              busy;
  logic              done;
  logic              err;
  logic [CNT_W-1:0]  pcount;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  clk_gen_ctrl #(.RATE_W(RATE_W), .CNT_W(CNT_W)) dut (
    .clk_i           (clk),
    .arst_n_i        (arst_n),
    .clk_en_i        (clk_en),
    .cfg_valid_i     (cfg_valid),
    .cfg_ready_o     (cfg_ready),
    .cfg_high_rate_i (cfg_high),
    .cfg_low_rate_i  (cfg_low),
    .cfg_polarity_i  (cfg_pol),
    .cfg_periods_i   (cfg_periods),
    .stop_req_i      (stop_req),
    .gen_clk_i       (gclk),
    .gen_init_o      (gen_init),
    .gen_en_o        (gen_en),
    .gen_high_rate_o (gen_high),
    .gen_low_rate_o  (gen_low),
    .gen_polarity_o  (gen_pol),
    .busy_o          (busy),
    .done_o          (done),
    .err_o           (err),
    .period_count_o  (pcount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural generator: level held for high/low enabled cycles.
  logic [RATE_W-1:0] gcnt;
  logic [RATE_W-1:0] glen;
  assign glen = gclk ? gen_high : gen_low;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      gclk <= 1'b0;
      gcnt <= '0;
    end else if (clk_en) begin
      if (gen_init) begin
        gclk <= gen_pol;
        gcnt <= '0;
      end else if (gen_en) begin
        if (gcnt == glen - 8'd1) begin
          gclk <= ~gclk;
          gcnt <= '0;
        end else begin
          gcnt <= gcnt + 8'd1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
  end

  // Present one configuration; returns #1 after the handshake edge.
  task automatic apply_cfg(input logic [7:0] hi, input logic [7:0] lo,
                           input logic pol, input logic [3:0] per);
    @(posedge clk); #1;
    cfg_high = hi; cfg_low = lo; cfg_pol = pol; cfg_periods = per;
    cfg_valid = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset;
    #3;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    total++; if ({gen_init, gen_en, done, err} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {gen_init, gen_en, done, err}); end
    total++; if (pcount !== 4'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", pcount); end
    total++; if (gen_high !== 8'd0) begin bad++; $display("FAIL rst_high got=%0d exp=0", gen_high); end
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", cfg_ready); end
  endtask

  task automatic test_basic;
    int base;
    int rises;
    logic gprev;
    logic got;
    base = done_cnt;
    apply_cfg(8'd2, 8'd3, 1'b0, 4'd4);
    total++; if ({gen_init, gen_en, busy, cfg_ready} !== 4'b1010) begin bad++; $display("FAIL basic_init got=%b exp=1010", {gen_init, gen_en, busy, cfg_ready}); end
    @(posedge clk); #1;
    total++; if ({gen_init, gen_en, busy} !== 3'b011) begin bad++; $display("FAIL basic_run got=%b exp=011", {gen_init, gen_en, busy}); end
    rises = 0; gprev = 1'b0; got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (gclk && !gprev) rises++;
      gprev = gclk;
      if (done) got = 1'b1;
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL basic_done_timeout got=%b exp=1", got); end
    total++; if (rises != 4) begin bad++; $display("FAIL basic_rises got=%0d exp=4", rises); end
    total++; if (pcount !== 4'd4) begin bad++; $display("FAIL basic_count got=%0d exp=4", pcount); end
    total++; if ({gclk, busy, cfg_ready} !== 3'b001) begin bad++; $display("FAIL basic_idle got=%b exp=001", {gclk, busy, cfg_ready}); end
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_width got=%b exp=0", done); end
    repeat (4) @(negedge clk);
    total++; if (done_cnt - base != 1) begin bad++; $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - base); end
    total++; if ({pcount, gclk} !== {4'd4, 1'b0}) begin bad++; $display("FAIL basic_hold got=%0d/%b exp=4/0", pcount, gclk); end
  endtask

  task automatic test_reject;
    apply_cfg(8'd0, 8'd5, 1'b1, 4'd3);
    total++; if ({err, busy, cfg_ready} !== 3'b101) begin bad++; $display("FAIL rej_hi got=%b exp=101", {err, busy, cfg_ready}); end
    total++; if ({gen_high, gen_low, gen_pol} !== {8'd2, 8'd3, 1'b0}) begin bad++; $display("FAIL rej_cfg got=%0d/%0d/%b exp=2/3/0", gen_high, gen_low, gen_pol); end
    @(posedge clk); #1;
    total++; if ({err, busy} !== 2'b00) begin bad++; $display("FAIL rej_pulse got=%b exp=00", {err, busy}); end
    apply_cfg(8'd4, 8'd0, 1'b0, 4'd1);
    total++; if ({err, busy, cfg_ready} !== 3'b101) begin bad++; $display("FAIL rej_lo got=%b exp=101", {err, busy, cfg_ready}); end
  endtask

  task automatic test_stop;
    int base;
    base = done_cnt;
    apply_cfg(8'd1, 8'd1, 1'b1, 4'd0);
    @(posedge clk); #1;
    total++; if ({gclk, gen_en} !== 2'b11) begin bad++; $display("FAIL stop_r0 got=%b exp=11", {gclk, gen_en}); end
    stop_req = 1'b1;
    @(posedge clk); #1;
    stop_req = 1'b0;
    total++; if ({gclk, gen_en, done} !== 3'b010) begin bad++; $display("FAIL stop_r1 got=%b exp=010", {gclk, gen_en, done}); end
    @(posedge clk); #1;
    total++; if ({gclk, gen_en, done} !== 3'b100) begin bad++; $display("FAIL stop_edge got=%b exp=100", {gclk, gen_en, done}); end
    @(posedge clk); #1;
    total++; if ({done, busy, pcount} !== {1'b1, 1'b0, 4'd1}) begin bad++; $display("FAIL stop_done got=%b/%b/%0d exp=1/0/1", done, busy, pcount); end
    repeat (4) @(posedge clk); #1;
    total++; if ({gclk, done_cnt - base} !== {1'b1, 32'd1}) begin bad++; $display("FAIL stop_after got=%b/%0d exp=1/1", gclk, done_cnt - base); end
  endtask

  task automatic test_wrap;
    int base;
    logic seen15;
    logic wrapped;
    logic got;
    base = done_cnt;
    seen15 = 1'b0; wrapped = 1'b0;
    apply_cfg(8'd1, 8'd1, 1'b0, 4'd0);
    for (int i = 0; i < 100 && !wrapped; i++) begin
      @(negedge clk);
      if (pcount == 4'd15) seen15 = 1'b1;
      else if (seen15 && pcount == 4'd0) wrapped = 1'b1;
    end
    total++; if (wrapped !== 1'b1) begin bad++; $display("FAIL wrap_seen got=%b exp=1", wrapped); end
    total++; if ({busy, done_cnt - base} !== {1'b1, 32'd0}) begin bad++; $display("FAIL wrap_nodone got=%b/%0d exp=1/0", busy, done_cnt - base); end
    @(posedge clk); #1; stop_req = 1'b1;
    @(posedge clk); #1; stop_req = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL wrap_stop got=%b exp=1", got); end
  endtask

  task automatic test_clk_en;
    int edges;
    logic got;
    @(posedge clk); #1;
    cfg_high = 8'd2; cfg_low = 8'd3; cfg_pol = 1'b0; cfg_periods = 4'd2;
    cfg_valid = 1'b1; clk_en = 1'b1;
    @(posedge clk); #1;
    cfg_valid = 1'b0; clk_en = 1'b0;
    edges = 0; got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); edges++; #1;
      clk_en = ~clk_en;
      if (done) got = 1'b1;
      else if (err) begin bad++; total++; $display("FAIL en_err got=1 exp=0"); end
    end
    total++; if (got !== 1'b1) begin bad++; $display("FAIL en_done_timeout got=%b exp=1", got); end
    total++; if (edges != 24) begin bad++; $display("FAIL en_duration got=%0d exp=24", edges); end
    total++; if (pcount !== 4'd2) begin bad++; $display("FAIL en_count got=%0d exp=2", pcount); end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL en_done_width got=%b exp=0", done); end
    clk_en = 1'b1;
  endtask

  task automatic test_reset_mid_run;
    int base;
    logic got;
    apply_cfg(8'd2, 8'd3, 1'b0, 4'd0);
    repeat (5) @(posedge clk);
    base = done_cnt;
    #2; arst_n = 1'b0;
    #1;
    total++; if ({busy, gen_en, gen_init, done, err} !== 5'b00000) begin bad++; $display("FAIL arst_outs got=%b exp=00000", {busy, gen_en, gen_init, done, err}); end
    total++; if ({pcount, gen_high} !== {4'd0, 8'd0}) begin bad++; $display("FAIL arst_regs got=%0d/%0d exp=0/0", pcount, gen_high); end
    @(posedge clk); @(negedge clk); arst_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (done_cnt != base) begin bad++; $display("FAIL arst_nodone got=%0d exp=%0d", done_cnt, base); end
    apply_cfg(8'd3, 8'd1, 1'b1, 4'd1);
    total++; if ({busy, gen_init} !== 2'b11) begin bad++; $display("FAIL arst_accept got=%b exp=11", {busy, gen_init}); end
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    total++; if ({got, pcount} !== {1'b1, 4'd1}) begin bad++; $display("FAIL arst_rerun got=%b/%0d exp=1/1", got, pcount); end
  endtask

  initial begin
    arst_n = 1'b0; clk_en = 1'b1; cfg_valid = 1'b0; stop_req = 1'b0;
    cfg_high = '0; cfg_low = '0; cfg_pol = 1'b0; cfg_periods = '0;
    test_reset();
    test_basic();
    test_reject();
    test_stop();
    test_wrap();
    test_clk_en();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
